// File: rtl/pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx_pkg
// Brief    : Shared state encoding and default sizes for the pattern
//            serialiser.
// Revision : 1.0 - initial release
// ============================================================================
package pattern_tx_pkg;

    localparam int PT_WIDTH = 8;   // default pattern register width
    localparam int PT_LEN_W = 4;   // default width of length / repeat fields

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } pt_state_t;

endpackage : pattern_tx_pkg
`default_nettype wire

// File: rtl/pattern_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx_if
// Brief    : Request handshake and serial output bundle of pattern_tx.
//            master = requester/observer, slave = pattern_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic [LEN_W-1:0] in_rep;
    logic             in_ready;
    logic             X;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, in_len, in_rep,
        input  in_ready, X, x_valid, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_len, in_rep,
        output in_ready, X, x_valid, busy, done
    );
endinterface : pattern_tx_if
`default_nettype wire

// File: rtl/pattern_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx_shreg
// Brief    : Loadable pattern register with a bit-index down-counter.
//            next_bit_o is the pattern bit addressed by the index the counter
//            will hold after this edge, so the caller can register it into X.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_tx_shreg
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = PT_WIDTH,
    parameter int LEN_W = PT_LEN_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,     // capture data_i/len_i, index = len-1
    input  wire logic             advance_i,  // step index toward bit 0
    input  wire logic             reload_i,   // restart index at len-1 of latched pattern
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic [LEN_W-1:0] len_i,      // effective length, always 1..WIDTH
    output logic                  next_bit_o,
    output logic                  last_o      // index currently at bit 0
);

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sel_w;

    // Next-state of pattern, length and index; advance saturates at bit 0.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        idx_d     = idx_q;
        if (load_i) begin
            pattern_d = data_i;
            len_d     = len_i;
            idx_d     = len_i - LEN_W'(1);
        end else if (reload_i) begin
            idx_d     = len_q - LEN_W'(1);
        end else if (advance_i && (idx_q != '0)) begin
            idx_d     = idx_q - LEN_W'(1);
        end
        sel_w      = pattern_d >> idx_d;
        next_bit_o = sel_w[0];
        last_o     = (idx_q == '0);
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
        end
    end

endmodule : pattern_tx_shreg
`default_nettype wire

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx
// Brief    : Serialises the low len bits of a pattern MSB-first, repeating it
//            rep extra times with a one-cycle gap, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = PT_WIDTH,
    parameter int LEN_W = PT_LEN_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pattern_tx_if.slave bus
);

    pt_state_t        state_q;
    logic             x_q;
    logic             xv_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;
    logic [LEN_W-1:0] rep_q;

    logic             load_w;
    logic             advance_w;
    logic             reload_w;
    logic             next_bit_w;
    logic             last_w;
    logic [LEN_W-1:0] len_eff_w;

    // A length of 0 or one beyond the register width means the full width.
    always_comb begin
        len_eff_w = bus.in_len;
        if ((bus.in_len == '0) || (bus.in_len > LEN_W'(WIDTH)))
            len_eff_w = LEN_W'(WIDTH);
        load_w    = (state_q == ST_IDLE) && bus.in_valid;
        advance_w = (state_q == ST_SHIFT) && !last_w;
        reload_w  = (state_q == ST_SHIFT) && last_w && (rep_q != '0);
    end

    pattern_tx_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_w),
        .advance_i  (advance_w),
        .reload_i   (reload_w),
        .data_i     (bus.in_data),
        .len_i      (len_eff_w),
        .next_bit_o (next_bit_w),
        .last_o     (last_w)
    );

    // Frame sequencing FSM; every output is a register set one edge ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            rep_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= ST_SHIFT;
                        rep_q   <= bus.in_rep;
                        x_q     <= next_bit_w;
                        xv_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!last_w) begin
                        x_q <= next_bit_w;
                    end else if (rep_q != '0) begin
                        state_q <= ST_GAP;
                        rep_q   <= rep_q - LEN_W'(1);
                        x_q     <= 1'b0;
                        xv_q    <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                        x_q     <= 1'b0;
                        xv_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_SHIFT;
                    x_q     <= next_bit_w;
                    xv_q    <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // in_ready is held low for as long as reset is asserted.
    assign bus.in_ready = ready_q & rst_n;
    assign bus.X        = x_q;
    assign bus.x_valid  = xv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule : pattern_tx
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_tx
// Brief    : Directed self-checking bench for pattern_tx. Each cycle the
//            tuple {in_ready,busy,done,x_valid,X} is compared with a
//            hand-written per-cycle script: '1'/'0' data bit, 'g' gap,
//            'D' done cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_tx;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    pattern_tx_if #(.WIDTH(8), .LEN_W(4)) bus ();

    pattern_tx #(.WIDTH(8), .LEN_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] tuple_now();
        return {bus.in_ready, bus.busy, bus.done, bus.x_valid, bus.X};
    endfunction

    function automatic logic [4:0] tuple_of(input byte c);
        case (c)
            "1":     return 5'b01011;
            "0":     return 5'b01010;
            "g":     return 5'b01000;
            "D":     return 5'b01100;
            default: return 5'b10000;
        endcase
    endfunction

    // Call at a negedge with the DUT idle: checks in_ready, requests a
    // frame, then checks each following cycle against exp. If inj >= 0, a
    // conflicting request is pulsed during stream cycle inj. Returns at the
    // negedge of the last scripted cycle.
    task automatic run_frame(input string tag, input logic [7:0] d,
                             input logic [3:0] len, input logic [3:0] rep,
                             input string exp, input int inj);
        check({tag, ".idle"}, 32'(tuple_now()), 32'(5'b10000));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = len;
        bus.in_rep   = rep;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_len   = 4'd3;
        bus.in_rep   = 4'd5;
        for (int i = 0; i < exp.len(); i++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d", tag, i), 32'(tuple_now()), 32'(tuple_of(exp[i])));
            if (i == inj) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'hFF;
                bus.in_len   = 4'd8;
                bus.in_rep   = 4'd3;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        bus.in_rep   = '0;

        // Reset values: in_ready forced low while rst_n is low.
        repeat (2) @(negedge clk);
        check("rst.hold", 32'(tuple_now()), 32'(5'b00000));
        rst_n = 1'b1;
        @(negedge clk);

        // Full-width frame.
        run_frame("f94", 8'b1001_0100, 4'd8, 4'd0, "10010100D", -1);
        @(negedge clk);
        // Repeated 4-bit field, taken in the first idle cycle (back-to-back).
        run_frame("f0b", 8'h0B, 4'd4, 4'd2, "1011g1011g1011D", -1);
        @(negedge clk);
        // Length 0 and length beyond the width both mean 8 bits.
        run_frame("len0", 8'hA5, 4'd0, 4'd0, "10100101D", -1);
        @(negedge clk);
        run_frame("len12", 8'hA5, 4'd12, 4'd0, "10100101D", -1);
        @(negedge clk);
        // Single-bit field with one repeat.
        run_frame("len1", 8'h55, 4'd1, 4'd1, "1g1D", -1);
        @(negedge clk);
        // Short field uses only the low bits.
        run_frame("len3", 8'b1111_0110, 4'd3, 4'd0, "110D", -1);
        @(negedge clk);
        // Request during SHIFT must be ignored.
        run_frame("inj", 8'h96, 4'd8, 4'd0, "10010110D", 2);
        @(negedge clk);
        run_frame("after", 8'h3C, 4'd6, 4'd1, "111100g111100D", -1);
        @(negedge clk);

        // Reset on the third bit of an 8-bit frame.
        check("ab.idle", 32'(tuple_now()), 32'(5'b10000));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        bus.in_len   = 4'd8;
        bus.in_rep   = 4'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ab.b0", 32'(tuple_now()), 32'(5'b01011));
        @(negedge clk);
        check("ab.b1", 32'(tuple_now()), 32'(5'b01011));
        @(negedge clk);
        check("ab.b2", 32'(tuple_now()), 32'(5'b01010));
        rst_n = 1'b0;
        #1;
        check("ab.rst", 32'(tuple_now()), 32'(5'b00000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ab.hold%0d", i), 32'(tuple_now()), 32'(5'b00000));
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post", 8'hC3, 4'd8, 4'd0, "11000011D", -1);
        @(negedge clk);
        check("end.idle", 32'(tuple_now()), 32'(5'b10000));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pattern_tx
`default_nettype wire
